ts_pkt_rr_sched: RTL

//   Packet-granular round-robin scheduler sharing one byte-parallel TS output between N_CH TS sources
//   (e.g. several ts_gen-style generators or per-program FIFOs) ahead of the serialiser/scrambler.

---
 rtl/ts_pkg.sv | 14 +
 rtl/rr_arb_n.sv | 22 ++
 rtl/ts_pkt_rr_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// ts_pkg: shared TS constants, scheduler FSM encoding and clog2 helper
package ts_pkg;
   localparam int TS_PKT_LEN = 188;
   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] GAP = 2'd2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_arb_n.sv
// rr_arb_n: combinational round-robin pick starting one past the last grant
module rr_arb_n #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input logic [N_CH-1:0] req_i,
   input logic [CH_W-1:0] last_i,
   output logic [CH_W-1:0] gnt_idx_o,
   output logic gnt_vld_o
);
   logic [CH_W-1:0] idx;
   // walk the ring backwards so the nearest requester after last_i wins
   always_comb begin
      idx = '0;
      gnt_idx_o = '0;
      for (int k = N_CH; k >= 1; k--) begin
         idx = CH_W'((int'(last_i) + k) % N_CH);
         if (req_i[idx]) gnt_idx_o = idx;
      end
   end
   assign gnt_vld_o = |req_i;
endmodule

// File: rtl/ts_pkt_rr_sched.sv
// ts_pkt_rr_sched: packet-granular round-robin scheduler onto one byte-wide TS stream
module ts_pkt_rr_sched import ts_pkg::*; #(
   parameter int N_CH = 4,
   parameter int PKT_LEN = TS_PKT_LEN,
   parameter int GAP_CYC = 2,
   parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
   parameter int CH_W = clog2(N_CH)
) (
   input logic clk,
   input logic rst,
   input logic [N_CH-1:0] pkt_rdy,
   output logic [N_CH-1:0] rd_en,
   input logic [N_CH*8-1:0] rd_data,
   output logic out_valid,
   output logic out_sync,
   output logic [7:0] out_data,
   output logic [CH_W-1:0] out_ch,
   output logic sync_err,
   output logic busy
);
   localparam int BC_W = clog2(PKT_LEN);
   localparam int GC_W = 4;
   logic [1:0] state_q, state_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [GC_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CH_W-1:0] grant_q, grant_d, last_q, last_d;
   logic out_valid_q, out_sync_q;
   logic [CH_W-1:0] arb_idx;
   logic arb_vld, xfer, last_byte;
   logic [7:0] sel_data;

   rr_arb_n #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .req_i(pkt_rdy),
      .last_i(last_q),
      .gnt_idx_o(arb_idx),
      .gnt_vld_o(arb_vld)
   );

   assign xfer = state_q == XFER;
   assign last_byte = byte_cnt_q == BC_W'(PKT_LEN - 1);
   assign sel_data = rd_data[{grant_q, 3'b000} +: 8];

   // arbitrate in IDLE, stream PKT_LEN bytes, then hold off GAP_CYC cycles
   always_comb begin
      state_d = state_q;
      byte_cnt_d = byte_cnt_q;
      gap_cnt_d = gap_cnt_q;
      grant_d = grant_q;
      last_d = last_q;
      if (state_q == IDLE) begin
         if (arb_vld) begin
            state_d = XFER;
            grant_d = arb_idx;
            last_d = arb_idx;
            byte_cnt_d = '0;
         end
      end else if (xfer) begin
         byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
         if (last_byte) begin
            state_d = (GAP_CYC == 0) ? IDLE : GAP;
            gap_cnt_d = (GAP_CYC == 0) ? '0 : GC_W'(GAP_CYC - 1);
         end
      end else if (state_q == GAP) begin
         state_d = (gap_cnt_q == '0) ? IDLE : GAP;
         gap_cnt_d = (gap_cnt_q == '0) ? '0 : gap_cnt_q - 1'b1;
      end else begin
         state_d = IDLE;
      end
   end

   // control state; pointer resets to the top channel so channel 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         byte_cnt_q <= '0;
         gap_cnt_q <= '0;
         grant_q <= '0;
         last_q <= CH_W'(N_CH - 1);
      end else begin
         state_q <= state_d;
         byte_cnt_q <= byte_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         grant_q <= grant_d;
         last_q <= last_d;
      end
   end

   // output framing lags rd_en by one cycle to line up with the source byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sync_q <= 1'b0;
      end else begin
         out_valid_q <= xfer;
         out_sync_q <= xfer && (byte_cnt_q == '0);
      end
   end

   assign rd_en = {{(N_CH-1){1'b0}}, xfer} << grant_q;
   assign out_valid = out_valid_q;
   assign out_sync = out_sync_q;
   assign out_data = out_valid_q ? sel_data : 8'h00;
   assign sync_err = out_sync_q && (sel_data != SYNC_BYTE);
   assign out_ch = grant_q;
   assign busy = state_q != IDLE;
endmodule
